h14tx_pll_rst_ctrl: RTL and testbench



---
 rtl/h14tx_pkg.sv | 27 ++
 rtl/h14tx_sync_2ff.sv | 22 ++
 rtl/h14tx_pll_rst_ctrl.sv | 131 +++++++++++++
 tb/tb_h14tx_pll_rst_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/h14tx_pkg.sv
// Shared types and helpers for the HDMI 1.4 TX PLL reset sequencer.
// Combinational only; no latency, no backpressure.
package h14tx_pkg;

  localparam int RETRY_W = 3;
  localparam logic [RETRY_W-1:0] RETRY_SAT = '1;

  typedef enum logic [2:0] {
    RESET     = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    LOCKED    = 3'd3,
    FAULT     = 3'd4
  } pll_rst_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Attempt counter sticks at all-ones so a long flapping history never looks fresh.
  function automatic logic [RETRY_W-1:0] retry_inc(input logic [RETRY_W-1:0] r);
    return (r == RETRY_SAT) ? r : r + RETRY_W'(1);
  endfunction

endpackage

// File: rtl/h14tx_sync_2ff.sv
// Generic single-bit two-flop synchronizer, async active-low reset to 0.
// Latency 2 clk edges; no backpressure.
module h14tx_sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/h14tx_pll_rst_ctrl.sv
// PLL reset/lock sequencer on the reference clock; H14TX_PLL_LOCK_SYNC_EN adds a 2-flop lock synchronizer.
// Outputs registered: pll_lock to lock = STABLE_CYCLES+3 edges (STABLE_CYCLES+1 without the synchronizer).
// No backpressure; soft_rst_req is a one-cycle pulse that always wins.
module h14tx_pll_rst_ctrl
  import h14tx_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pll_lock,
  input  logic               soft_rst_req,
  output logic               pll_rst,
  output logic               lock,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_cnt
);

  localparam int CNT_W = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) + 1;

  localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STB_LAST    = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

  logic lock_s;

`ifdef H14TX_PLL_LOCK_SYNC_EN
  h14tx_sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );
`else
  assign lock_s = pll_lock;
`endif

  pll_rst_state_e     state;
  pll_rst_state_e     state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [RETRY_W-1:0] retry_nxt;
  logic [RETRY_W-1:0] retry_bump;
  logic               fail;

  assign retry_bump = retry_inc(retry_cnt);

  // The counter holds the number of edges already spent in the current state;
  // it restarts from zero on every state entry.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_ONE;
    retry_nxt = retry_cnt;
    fail      = 1'b0;

    case (state)
      RESET: begin
        if (cnt == RST_LAST) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end else if (cnt == TO_LAST) begin
          fail = 1'b1;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          fail = 1'b1;
        end else if (cnt == STB_LAST) begin
          state_nxt = LOCKED;
          cnt_nxt   = '0;
        end
      end
      LOCKED: begin
        cnt_nxt = '0;
        // Losing lock here is a relock attempt, but it still consumes a retry.
        if (!lock_s) begin
          fail = 1'b1;
        end
      end
      FAULT: begin
        cnt_nxt = '0;
      end
      default: begin
        state_nxt = RESET;
        cnt_nxt   = '0;
      end
    endcase

    if (fail) begin
      retry_nxt = retry_bump;
      state_nxt = (retry_bump >= RETRY_LIMIT) ? FAULT : RESET;
      cnt_nxt   = '0;
    end

    if (soft_rst_req) begin
      state_nxt = RESET;
      cnt_nxt   = '0;
      retry_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RESET;
      cnt       <= '0;
      retry_cnt <= '0;
      pll_rst   <= 1'b1;
      lock      <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      retry_cnt <= retry_nxt;
      pll_rst   <= (state_nxt == RESET) || (state_nxt == FAULT);
      lock      <= (state_nxt == LOCKED);
      fault     <= (state_nxt == FAULT);
    end
  end

endmodule

// File: tb/tb_h14tx_pll_rst_ctrl.sv
// Directed bench for h14tx_pll_rst_ctrl with small parameters.
// Lock latency expectations follow whether H14TX_PLL_LOCK_SYNC_EN is defined for the build.
module tb_h14tx_pll_rst_ctrl;

  localparam int RST_C = 4;
  localparam int TO    = 32;
  localparam int STB   = 8;
  localparam int MAXR  = 2;
`ifdef H14TX_PLL_LOCK_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic       pll_lock;
  logic       soft_rst_req;
  logic       pll_rst;
  logic       lock;
  logic       fault;
  logic [2:0] retry_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  h14tx_pll_rst_ctrl #(
    .RST_CYCLES    (RST_C),
    .LOCK_TIMEOUT  (TO),
    .STABLE_CYCLES (STB),
    .MAX_RETRIES   (MAXR)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_lock     (pll_lock),
    .soft_rst_req (soft_rst_req),
    .pll_rst      (pll_rst),
    .lock         (lock),
    .fault        (fault),
    .retry_cnt    (retry_cnt)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    int         gap;
    logic       drv_lock;
    logic       drv_soft;
    logic       e_rst;
    logic       e_lock;
    logic       e_fault;
    logic [2:0] e_retry;
    string      name;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int g, input logic dl, input logic ds, input logic er,
                     input logic el, input logic ef, input logic [2:0] erc, input string nm);
    vec_t v;
    v.gap = g; v.drv_lock = dl; v.drv_soft = ds;
    v.e_rst = er; v.e_lock = el; v.e_fault = ef; v.e_retry = erc; v.name = nm;
    tbl.push_back(v);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endtask

  task automatic chk3(input string nm, input logic [2:0] act, input logic [2:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic chk_all(input string nm, input logic er, input logic el,
                         input logic ef, input logic [2:0] erc);
    chk1({nm, ".pll_rst"}, pll_rst, er);
    chk1({nm, ".lock"}, lock, el);
    chk1({nm, ".fault"}, fault, ef);
    chk3({nm, ".retry_cnt"}, retry_cnt, erc);
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n        = 1'b0;
    pll_lock     = 1'b0;
    soft_rst_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all("in_reset", 1'b1, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // gap, drive lock, drive soft | pll_rst lock fault retry | name
    add(0,     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, "released");
    add(3,     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, "rst_high_e2");
    add(1,     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, "rst_fall_e3");
    add(2,     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, "wait_e5");
    add(STB+L, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, "lock_early");
    add(1,     1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, "lock_rise");
    add(4,     1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, "locked_hold");
    add(L,     1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, "drop_pre");
    add(1,     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, "drop_clear");
    add(3,     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, "relock_rst_hi");
    add(1,     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, "relock_rst_fall");
    add(8,     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, "relock_early");
    add(1,     1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, "relocked");
    add(1,     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, "soft_from_locked");
    add(3,     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, "soft_rst_hi");
    add(1,     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, "soft_wait");
    add(3,     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, "stable_run");
    add(3,     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, "stable_fail");
    add(L+1,   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, "retry_rst_hi");
    add(1,     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, "retry_rst_fall");
    add(8,     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, "retry_early");
    add(1,     1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, "retry_locked");

    for (int i = 0; i < tbl.size(); i++) begin
      adv(tbl[i].gap);
      chk_all(tbl[i].name, tbl[i].e_rst, tbl[i].e_lock, tbl[i].e_fault, tbl[i].e_retry);
      pll_lock     = tbl[i].drv_lock;
      soft_rst_req = tbl[i].drv_soft;
    end

    // Short async reset pulse while LOCKED, mid-cycle, then full restart with lock held low.
    @(posedge clk);
    #3;
    rst_n    = 1'b0;
    pll_lock = 1'b0;
    #1;
    chk_all("arst_async", 1'b1, 1'b0, 1'b0, 3'd0);
    #1;
    rst_n = 1'b1;
    adv(3);  chk_all("arst_rst_hi", 1'b1, 1'b0, 1'b0, 3'd0);
    adv(1);  chk_all("arst_rst_fall", 1'b0, 1'b0, 1'b0, 3'd0);
    adv(31); chk_all("to1_pre", 1'b0, 1'b0, 1'b0, 3'd0);
    adv(1);  chk_all("to1_retry", 1'b1, 1'b0, 1'b0, 3'd1);
    adv(3);  chk_all("to1_rst_hi", 1'b1, 1'b0, 1'b0, 3'd1);
    adv(1);  chk_all("to1_rst_fall", 1'b0, 1'b0, 1'b0, 3'd1);
    adv(31); chk_all("to2_pre", 1'b0, 1'b0, 1'b0, 3'd1);
    adv(1);  chk_all("fault_entry", 1'b1, 1'b0, 1'b1, 3'd2);
    pll_lock = 1'b1;
    adv(20); chk_all("fault_sticky", 1'b1, 1'b0, 1'b1, 3'd2);

    // Soft restart out of FAULT, then soft request landing on a timeout edge.
    soft_rst_req = 1'b1;
    adv(1);
    soft_rst_req = 1'b0;
    chk_all("soft_from_fault", 1'b1, 1'b0, 1'b0, 3'd0);
    pll_lock = 1'b0;
    adv(35); chk_all("s_to1_pre", 1'b0, 1'b0, 1'b0, 3'd0);
    adv(1);  chk_all("s_to1_retry", 1'b1, 1'b0, 1'b0, 3'd1);
    adv(35); chk_all("s_to2_pre", 1'b0, 1'b0, 1'b0, 3'd1);
    soft_rst_req = 1'b1;
    adv(1);
    soft_rst_req = 1'b0;
    chk_all("soft_vs_timeout", 1'b1, 1'b0, 1'b0, 3'd0);
    adv(4);  chk_all("soft_vs_to_wait", 1'b0, 1'b0, 1'b0, 3'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
